dcim_job_sequencer: RTL and testbench
=====================================

// Module: dcim_job_sequencer
// PURPOSE
//  Host-side controller for the DCIM macro (top). Accepts weight-row write bursts and compute jobs over
//  valid/ready, drives the macro's D/WA/acm_en/cima/inwidth/wwidth/start/xin0 pins with correct sequencing,
//  detects completion on st, and returns the captured nout over a held valid/ready result channel.
//  Includes a watchdog so a hung macro cannot stall the host.
// PARAMETERS
//  NROWS    8    weight rows in macro; WA is one-hot over NROWS
//  DW       24   weight word width (D)
//  XW       192  activation vector width (xin0)
//  OW       51   result width (nout)
//  TIMEOUT  255  max cycles in WAIT before forced abort; must be >=1
// PORTS
//  clk          in   1                      single clock, rising edge
//  rstn         in   1                      synchronous, active-low reset
//  w_valid      in   1                      weight beat valid
//  w_ready      out  1                      weight beat accepted when w_valid&w_ready
//  w_row        in   $clog2(NROWS)          target row index
//  w_data       in   DW                     weight word
//  w_last       in   1                      final beat of burst
//  job_valid    in   1                      compute job valid
//  job_ready    out  1                      job accepted when job_valid&job_ready
//  job_inwidth  in   1                      0=12-bit input, 1=alt width (passed to macro)
//  job_wwidth   in   1                      0=12-bit weight, 1=alt width
//  job_xin      in   XW                     activation vector
//  res_valid    out  1                      result valid, held until res_ready
//  res_ready    in   1                      host accepts result
//  res_data     out  OW                     captured nout (0 on timeout)
//  res_timeout  out  1                      1 = job aborted by watchdog
//  busy         out  1                      state != IDLE
//  m_D          out  DW                     to macro D
//  m_WA         out  NROWS                  to macro WA (one-hot or 0)
//  m_acm_en     out  1                      to macro acm_en
//  m_cima       out  1                      to macro cima
//  m_inwidth    out  1                      to macro inwidth
//  m_wwidth     out  1                      to macro wwidth
//  m_start      out  1                      to macro start
//  m_xin0       out  XW                     to macro xin0
//  m_nout       in   OW                     from macro nout
//  m_st         in   1                      from macro st (done)
// BEHAVIOUR
//  Reset (rstn=0 at edge): state IDLE; all outputs 0; watchdog 0; pending job/result discarded. Applies
//   mid-operation too: macro pins return to 0 on that same edge.
//  All macro-side outputs are registered. m_acm_en=1 whenever not in reset; m_cima=0 in LOAD/GAP/IDLE.
//  FSM:
//   IDLE:  w_ready=1, job_ready=0 if w_valid (weights win), else job_ready=1.
//          w accept -> LOAD actions for that beat; job accept -> latch widths/xin, -> ARM.
//   LOAD:  each accepted beat drives m_WA=1<<w_row, m_D=w_data for exactly one cycle. w_ready=1.
//          No beat that cycle -> m_WA=0, stay. Beat with w_last -> GAP.
//   GAP:   one cycle m_WA=0, m_D=0, w_ready=0 -> IDLE.
//   ARM:   m_xin0/m_inwidth/m_wwidth/m_cima=1 valid, m_start=0 (1-cycle setup) -> START.
//   START: m_start=1 for exactly one cycle -> WAIT; watchdog cleared.
//   WAIT:  m_start=0. Rising edge of m_st (m_st=1, registered prior value 0) -> CAPTURE.
//          Watchdog counts each WAIT cycle; reaching TIMEOUT -> RESP with res_timeout=1, res_data=0.
//          m_st already high on WAIT entry does NOT count; a fresh rising edge is required.
//   CAPTURE: res_data<=m_nout sampled this cycle, res_timeout<=0 -> RESP.
//   RESP:  res_valid=1, res_data/res_timeout stable; m_cima=0, m_xin0 held. res_ready -> IDLE same edge.
//  job_ready and w_ready are 0 in ARM..RESP; weights cannot change during compute.
//  Latency: job accept to m_start=1 is 2 cycles; m_st rise to res_valid is 2 cycles.
//  Simultaneous w_valid & job_valid in IDLE: weight beat taken, job waits.
//  Watchdog counter is $clog2(TIMEOUT+1) bits, saturates, never wraps.
// STRUCTURE
//  Package dcim_ctrl_pkg: state enum (IDLE,LOAD,GAP,ARM,START,WAIT,CAPTURE,RESP), default widths
//   DCIM_DW/XW/OW/NROWS, one-hot helper function row2wa().
//  Sub-module dcim_watchdog (clear, enable, TIMEOUT param -> expired pulse); rest is a single FSM.
// TESTING
//  1 burst rows 0..7 data 1..8, w_last on row 7 -> m_WA 01,02,..,80 one cycle each, then one cycle 00.
//  2 job xin all-ones, widths 0 -> m_start single-cycle pulse 2 cycles after accept; model m_st
//    rise 20 cycles later with nout=51'h1234 -> res_valid=1, res_data=51'h1234, res_timeout=0.
//  3 res_ready held 0 for 10 cycles -> res_valid/res_data stable; job_ready=0 throughout; accept -> IDLE.
//  4 m_st never rises, TIMEOUT=16 -> res_valid after 16 WAIT cycles, res_timeout=1, res_data=0.
//  5 w_valid and job_valid together in IDLE -> weight burst completes (incl. GAP) before ARM.
//  6 rstn=0 during WAIT -> next edge all outputs 0, busy=0; post-reset job runs normally.

Source files
------------

// File: rtl/dcim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcim_ctrl_pkg
//  Description : Shared types, default widths and helpers for the DCIM
//                host-side job sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package dcim_ctrl_pkg;

    localparam int DCIM_DW     = 24;
    localparam int DCIM_XW     = 192;
    localparam int DCIM_OW     = 51;
    localparam int DCIM_NROWS  = 8;
    // Widest row-select vector the one-hot helper can produce
    localparam int DCIM_WA_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_GAP     = 3'd2,
        ST_ARM     = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_CAPTURE = 3'd6,
        ST_RESP    = 3'd7
    } dcim_state_t;

    // Row index to one-hot write-address; caller truncates to its row count
    function automatic logic [DCIM_WA_MAX-1:0] row2wa(input int row);
        return 64'd1 << row;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcim_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : dcim_watchdog
//  Description : Saturating cycle counter. Counts enabled cycles since the
//                last clear and flags the cycle in which the TIMEOUT-th
//                enabled cycle occurs.
//  Revision    : 1.0  initial release
// ============================================================================
module dcim_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_sat  = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_cnt;

    // Count enabled cycles, holding at TIMEOUT so the counter never wraps
    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != c_sat)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the cycles already spent, so this is the TIMEOUT-th one
    assign o_expired = i_enable && (r_cnt >= c_last);

endmodule
`default_nettype wire

// File: rtl/dcim_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dcim_job_sequencer
//  Description : Host-side controller for the DCIM macro. Streams weight
//                rows, sequences compute jobs (setup, start pulse, wait for
//                done), returns the result, and aborts hung jobs.
//  Revision    : 1.0  initial release
// ============================================================================
module dcim_job_sequencer
    import dcim_ctrl_pkg::*;
#(
    parameter int NROWS   = DCIM_NROWS,
    parameter int DW      = DCIM_DW,
    parameter int XW      = DCIM_XW,
    parameter int OW      = DCIM_OW,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [$clog2(NROWS)-1:0] w_row,
    input  logic [DW-1:0]            w_data,
    input  logic                     w_last,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic                     job_inwidth,
    input  logic                     job_wwidth,
    input  logic [XW-1:0]            job_xin,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OW-1:0]            res_data,
    output logic                     res_timeout,
    output logic                     busy,
    output logic [DW-1:0]            m_D,
    output logic [NROWS-1:0]         m_WA,
    output logic                     m_acm_en,
    output logic                     m_cima,
    output logic                     m_inwidth,
    output logic                     m_wwidth,
    output logic                     m_start,
    output logic [XW-1:0]            m_xin0,
    input  logic [OW-1:0]            m_nout,
    input  logic                     m_st
);

    dcim_state_t       r_state;
    dcim_state_t       w_nxt_state;

    logic [DW-1:0]     r_d,           w_nxt_d;
    logic [NROWS-1:0]  r_wa,          w_nxt_wa;
    logic              r_acm_en;
    logic              r_cima,        w_nxt_cima;
    logic              r_inwidth,     w_nxt_inwidth;
    logic              r_wwidth,      w_nxt_wwidth;
    logic              r_start,       w_nxt_start;
    logic [XW-1:0]     r_xin0,        w_nxt_xin0;
    logic              r_res_valid,   w_nxt_res_valid;
    logic [OW-1:0]     r_res_data,    w_nxt_res_data;
    logic              r_res_timeout, w_nxt_res_timeout;
    logic              r_st_prev;

    logic              w_w_ready;
    logic              w_job_ready;
    logic              w_wd_clear;
    logic              w_wd_en;
    logic              w_wd_expired;

    dcim_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_en),
        .o_expired (w_wd_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next state plus next value of every registered macro/result output
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_d           = '0;
        w_nxt_wa          = '0;
        w_nxt_inwidth     = r_inwidth;
        w_nxt_wwidth      = r_wwidth;
        w_nxt_xin0        = r_xin0;
        w_nxt_res_data    = r_res_data;
        w_nxt_res_timeout = r_res_timeout;
        w_w_ready         = 1'b0;
        w_job_ready       = 1'b0;
        w_wd_clear        = 1'b0;
        w_wd_en           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A pending weight beat always beats a pending job
                w_w_ready   = 1'b1;
                w_job_ready = !w_valid;
                if (w_valid) begin
                    w_nxt_wa    = NROWS'(row2wa(int'(w_row)));
                    w_nxt_d     = w_data;
                    w_nxt_state = w_last ? ST_GAP : ST_LOAD;
                end else if (job_valid) begin
                    w_nxt_inwidth = job_inwidth;
                    w_nxt_wwidth  = job_wwidth;
                    w_nxt_xin0    = job_xin;
                    w_nxt_state   = ST_ARM;
                end
            end
            ST_LOAD: begin
                w_w_ready = 1'b1;
                if (w_valid) begin
                    w_nxt_wa = NROWS'(row2wa(int'(w_row)));
                    w_nxt_d  = w_data;
                    if (w_last) begin
                        w_nxt_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                w_nxt_state = ST_IDLE;
            end
            ST_ARM: begin
                w_nxt_state = ST_START;
            end
            ST_START: begin
                w_wd_clear  = 1'b1;
                w_nxt_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_wd_en = 1'b1;
                // Only a fresh low-to-high transition of st marks completion
                if (m_st && !r_st_prev) begin
                    w_nxt_state = ST_CAPTURE;
                end else if (w_wd_expired) begin
                    w_nxt_res_data    = '0;
                    w_nxt_res_timeout = 1'b1;
                    w_nxt_state       = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                w_nxt_res_data    = m_nout;
                w_nxt_res_timeout = 1'b0;
                w_nxt_state       = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // Outputs registered from the next state so they line up with it
        w_nxt_cima      = (w_nxt_state == ST_ARM)  || (w_nxt_state == ST_START) ||
                          (w_nxt_state == ST_WAIT) || (w_nxt_state == ST_CAPTURE);
        w_nxt_start     = (w_nxt_state == ST_START);
        w_nxt_res_valid = (w_nxt_state == ST_RESP);
    end

    // Output and edge-detect registers; reset drives every macro pin low
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_d           <= '0;
            r_wa          <= '0;
            r_acm_en      <= 1'b0;
            r_cima        <= 1'b0;
            r_inwidth     <= 1'b0;
            r_wwidth      <= 1'b0;
            r_start       <= 1'b0;
            r_xin0        <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
            r_st_prev     <= 1'b0;
        end else begin
            r_d           <= w_nxt_d;
            r_wa          <= w_nxt_wa;
            r_acm_en      <= 1'b1;
            r_cima        <= w_nxt_cima;
            r_inwidth     <= w_nxt_inwidth;
            r_wwidth      <= w_nxt_wwidth;
            r_start       <= w_nxt_start;
            r_xin0        <= w_nxt_xin0;
            r_res_valid   <= w_nxt_res_valid;
            r_res_data    <= w_nxt_res_data;
            r_res_timeout <= w_nxt_res_timeout;
            r_st_prev     <= m_st;
        end
    end

    // Readies are held low while reset is asserted
    assign w_ready     = rstn && w_w_ready;
    assign job_ready   = rstn && w_job_ready;
    assign busy        = (r_state != ST_IDLE);

    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_timeout = r_res_timeout;
    assign m_D         = r_d;
    assign m_WA        = r_wa;
    assign m_acm_en    = r_acm_en;
    assign m_cima      = r_cima;
    assign m_inwidth   = r_inwidth;
    assign m_wwidth    = r_wwidth;
    assign m_start     = r_start;
    assign m_xin0      = r_xin0;

endmodule
`default_nettype wire

// File: tb/tb_dcim_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcim_job_sequencer
//  Description : Directed self-checking bench for dcim_job_sequencer. A
//                second instance with a short watchdog and st tied low
//                exercises the abort path.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcim_job_sequencer;

    localparam int NROWS = 8;
    localparam int DW    = 24;
    localparam int XW    = 192;
    localparam int OW    = 51;

    logic             clk;
    logic             rstn;
    logic             w_valid;
    logic [2:0]       w_row;
    logic [DW-1:0]    w_data;
    logic             w_last;
    logic             job_valid;
    logic             job_inwidth;
    logic             job_wwidth;
    logic [XW-1:0]    job_xin;
    logic             res_ready;
    logic [OW-1:0]    m_nout;
    logic             m_st;

    logic             w_ready, job_ready, res_valid, res_timeout, busy;
    logic [OW-1:0]    res_data;
    logic [DW-1:0]    m_D;
    logic [NROWS-1:0] m_WA;
    logic             m_acm_en, m_cima, m_inwidth, m_wwidth, m_start;
    logic [XW-1:0]    m_xin0;

    // Watchdog instance stimulus and observation
    logic             w_valid2, jv2, rr2, st2;
    logic             w_ready2, job_ready2, res_valid2, res_timeout2, busy2;
    logic [OW-1:0]    res_data2;
    logic [DW-1:0]    m_D2;
    logic [NROWS-1:0] m_WA2;
    logic             m_acm_en2, m_cima2, m_inwidth2, m_wwidth2, m_start2;
    logic [XW-1:0]    m_xin02;

    int n_chk = 0;
    int n_bad = 0;

    dcim_job_sequencer #(.TIMEOUT(255)) dut (
        .clk(clk), .rstn(rstn),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .w_data(w_data), .w_last(w_last),
        .job_valid(job_valid), .job_ready(job_ready), .job_inwidth(job_inwidth),
        .job_wwidth(job_wwidth), .job_xin(job_xin),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout), .busy(busy),
        .m_D(m_D), .m_WA(m_WA), .m_acm_en(m_acm_en), .m_cima(m_cima),
        .m_inwidth(m_inwidth), .m_wwidth(m_wwidth), .m_start(m_start),
        .m_xin0(m_xin0), .m_nout(m_nout), .m_st(m_st)
    );

    dcim_job_sequencer #(.TIMEOUT(16)) dut_wd (
        .clk(clk), .rstn(rstn),
        .w_valid(w_valid2), .w_ready(w_ready2), .w_row(w_row), .w_data(w_data), .w_last(w_last),
        .job_valid(jv2), .job_ready(job_ready2), .job_inwidth(job_inwidth),
        .job_wwidth(job_wwidth), .job_xin(job_xin),
        .res_valid(res_valid2), .res_ready(rr2), .res_data(res_data2),
        .res_timeout(res_timeout2), .busy(busy2),
        .m_D(m_D2), .m_WA(m_WA2), .m_acm_en(m_acm_en2), .m_cima(m_cima2),
        .m_inwidth(m_inwidth2), .m_wwidth(m_wwidth2), .m_start(m_start2),
        .m_xin0(m_xin02), .m_nout(m_nout), .m_st(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled at negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=hung expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_wa;
        int         n;

        rstn = 1'b0; w_valid = 1'b0; w_row = '0; w_data = '0; w_last = 1'b0;
        job_valid = 1'b0; job_inwidth = 1'b0; job_wwidth = 1'b0; job_xin = '0;
        res_ready = 1'b0; m_nout = '0; m_st = 1'b0;
        w_valid2 = 1'b0; jv2 = 1'b0; rr2 = 1'b0; st2 = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_m_wa", m_WA, 0);
        check("rst_acm_en", m_acm_en, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_w_ready", w_ready, 0);
        rstn = 1'b1;
        tick();
        check("idle_acm_en", m_acm_en, 1);
        check("idle_w_ready", w_ready, 1);
        check("idle_job_ready", job_ready, 1);

        // ---------------- 1: weight burst rows 0..7 ----------------
        for (int i = 0; i < 8; i++) begin
            w_valid = 1'b1; w_row = 3'(i); w_data = 24'(i + 1); w_last = (i == 7);
            #1;
            check("t1_w_ready", w_ready, 1);
            tick();
            exp_wa = 8'd1 << i;
            check("t1_m_wa", m_WA, exp_wa);
            check("t1_m_d", m_D, i + 1);
        end
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        check("t1_gap_w_ready", w_ready, 0);
        check("t1_gap_busy", busy, 1);
        tick();
        check("t1_after_wa", m_WA, 0);
        check("t1_after_d", m_D, 0);
        check("t1_after_busy", busy, 0);

        // ---------------- 2: compute job, st rises 20 cycles after start ----------------
        job_xin = '1; job_inwidth = 1'b0; job_wwidth = 1'b0; job_valid = 1'b1;
        #1;
        check("t2_job_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
        #1;
        check("t2_arm_start", m_start, 0);
        check("t2_arm_cima", m_cima, 1);
        check("t2_arm_xin", m_xin0, {XW{1'b1}});
        check("t2_arm_job_ready", job_ready, 0);
        tick();
        check("t2_start_pulse", m_start, 1);
        tick();
        check("t2_start_low", m_start, 0);
        check("t2_wait_cima", m_cima, 1);
        repeat (19) tick();
        check("t2_no_early_valid", res_valid, 0);
        m_nout = 51'h1234; m_st = 1'b1;
        tick();
        check("t2_capture_valid", res_valid, 0);
        tick();
        check("t2_res_valid", res_valid, 1);
        check("t2_res_data", res_data, 51'h1234);
        check("t2_res_timeout", res_timeout, 0);
        check("t2_resp_cima", m_cima, 0);
        check("t2_resp_xin", m_xin0, {XW{1'b1}});

        // ---------------- 3: result held while host stalls ----------------
        m_st = 1'b0; job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_data", res_data, 51'h1234);
            check("t3_job_ready", job_ready, 0);
        end
        job_valid = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t3_released_valid", res_valid, 0);
        check("t3_released_busy", busy, 0);

        // ---------------- 4: hung macro, TIMEOUT=16 ----------------
        jv2 = 1'b1;
        #1;
        check("t4_job_ready", job_ready2, 1);
        tick();
        jv2 = 1'b0;
        tick();
        check("t4_start_pulse", m_start2, 1);
        tick();
        n = 0;
        while (res_valid2 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t4_wait_cycles", n, 16);
        check("t4_res_timeout", res_timeout2, 1);
        check("t4_res_data", res_data2, 0);
        check("t4_resp_cima", m_cima2, 0);
        rr2 = 1'b1;
        tick();
        rr2 = 1'b0;
        check("t4_released_busy", busy2, 0);

        // ---------------- 5: weight beat wins over simultaneous job ----------------
        job_xin = 192'hABCD; job_valid = 1'b1;
        w_valid = 1'b1; w_row = 3'd2; w_data = 24'hAA; w_last = 1'b0;
        #1;
        check("t5_job_blocked", job_ready, 0);
        check("t5_w_ready", w_ready, 1);
        tick();
        check("t5_m_wa_row2", m_WA, 8'h04);
        w_row = 3'd5; w_data = 24'h55; w_last = 1'b1;
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        check("t5_m_wa_row5", m_WA, 8'h20);
        check("t5_gap_job_ready", job_ready, 0);
        check("t5_gap_start", m_start, 0);
        tick();
        check("t5_idle_wa", m_WA, 0);
        check("t5_idle_job_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
        check("t5_arm_cima", m_cima, 1);
        check("t5_arm_start", m_start, 0);
        tick();
        check("t5_start_pulse", m_start, 1);
        tick();

        // ---------------- 6: reset during WAIT ----------------
        check("t6_in_wait_busy", busy, 1);
        rstn = 1'b0;
        tick();
        check("t6_rst_m_wa", m_WA, 0);
        check("t6_rst_m_d", m_D, 0);
        check("t6_rst_start", m_start, 0);
        check("t6_rst_cima", m_cima, 0);
        check("t6_rst_xin", m_xin0, 0);
        check("t6_rst_acm_en", m_acm_en, 0);
        check("t6_rst_res_data", res_data, 0);
        check("t6_rst_res_valid", res_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_w_ready", w_ready, 0);
        check("t6_rst_job_ready", job_ready, 0);
        rstn = 1'b1;
        tick();
        check("t6_acm_en", m_acm_en, 1);

        // post-reset job; st already high on WAIT entry must not complete it
        job_xin = {96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, 96'h0123_4567_89AB_CDEF_0011_2233};
        job_inwidth = 1'b1; job_wwidth = 1'b1; job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        check("t6_inwidth", m_inwidth, 1);
        check("t6_wwidth", m_wwidth, 1);
        check("t6_xin", m_xin0, {96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, 96'h0123_4567_89AB_CDEF_0011_2233});
        m_nout = 51'h7_0000_0000_ABCD; m_st = 1'b1;
        tick();
        check("t6_start_pulse", m_start, 1);
        tick(); tick(); tick();
        check("t6_st_high_no_done", res_valid, 0);
        check("t6_still_waiting", m_cima, 1);
        m_st = 1'b0;
        tick();
        m_st = 1'b1;
        tick();
        check("t6_capture_valid", res_valid, 0);
        tick();
        check("t6_res_valid", res_valid, 1);
        check("t6_res_data", res_data, 51'h7_0000_0000_ABCD);
        check("t6_res_timeout", res_timeout, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0; m_st = 1'b0;
        check("t6_done_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
